// File: rtl/ldl_arb_pkg.sv
// Shared arbiter types and constants: state encoding, default hold limit, and a width helper.
// Combinational helpers only; no latency or backpressure of its own.
package ldl_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int DEF_MAX_HOLD = 16;

    // Bits needed to hold values 0..v-1, never less than 1.
    function automatic int safe_clog2(input int v);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ldl_rr_arb_lock_if.sv
// Request/grant bundle between requesters (master) and the locking arbiter (slave).
// The timeout pulse exists only when ARB_TIMEOUT_EN is defined.
interface ldl_rr_arb_lock_if #(
    parameter int BIN_WIDTH = 3
);
    localparam int N = 1 << BIN_WIDTH;

    logic [N-1:0]         req;
    logic                 xfer;
    logic                 last;
    logic [N-1:0]         gnt;
    logic [BIN_WIDTH-1:0] gnt_id;
    logic                 gnt_vld;
`ifdef ARB_TIMEOUT_EN
    logic                 timeout;

    modport master (output req, xfer, last, input gnt, gnt_id, gnt_vld, timeout);
    modport slave  (input req, xfer, last, output gnt, gnt_id, gnt_vld, timeout);
`else
    modport master (output req, xfer, last, input gnt, gnt_id, gnt_vld);
    modport slave  (input req, xfer, last, output gnt, gnt_id, gnt_vld);
`endif

endinterface

// File: rtl/ldl_rr_pick.sv
// Round-robin winner select: lowest asserted index above ptr, else lowest asserted overall.
// Purely combinational, zero latency, no backpressure.
module ldl_rr_pick #(
    parameter  int BIN_WIDTH = 3,
    localparam int N         = 1 << BIN_WIDTH
) (
    input  logic [N-1:0]         req,
    input  logic [BIN_WIDTH-1:0] ptr,
    output logic [N-1:0]         win,
    output logic [BIN_WIDTH-1:0] win_id,
    output logic                 any
);

    function automatic logic [BIN_WIDTH-1:0] lowest(input logic [N-1:0] v);
        logic [BIN_WIDTH-1:0] res;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) res = BIN_WIDTH'(i);
        end
        return res;
    endfunction

    logic [N-1:0]         above_mask;
    logic [N-1:0]         req_above;
    logic [BIN_WIDTH-1:0] id_above;
    logic [BIN_WIDTH-1:0] id_all;

    always_comb begin
        above_mask = '0;
        for (int i = 0; i < N; i++) begin
            above_mask[i] = (BIN_WIDTH'(i) > ptr);
        end
    end

    assign req_above = req & above_mask;
    assign id_above  = lowest(req_above);
    assign id_all    = lowest(req);
    assign any       = |req;
    assign win_id    = (|req_above) ? id_above : id_all;
    assign win       = any ? (N'(1) << win_id) : '0;

endmodule

// File: rtl/ldl_rr_arb_lock.sv
// Round-robin arbiter holding each grant for a whole packet; grant 1 cycle after req, no bubble on hand-over.
// No backpressure: release on xfer&last, owner abandon, or (with ARB_TIMEOUT_EN) a forced hold-limit timeout.
module ldl_rr_arb_lock
    import ldl_arb_pkg::*;
#(
    parameter  int BIN_WIDTH = 3,
    parameter  int MAX_HOLD  = DEF_MAX_HOLD,
    localparam int N         = 1 << BIN_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    ldl_rr_arb_lock_if.slave  bus
);

    if (MAX_HOLD < 2) begin : g_bad_max_hold
        $error("ldl_rr_arb_lock: MAX_HOLD must be at least 2");
    end

    arb_state_t           state_q, state_d;
    logic [N-1:0]         gnt_q, gnt_d;
    logic [BIN_WIDTH-1:0] gnt_id_q, gnt_id_d;
    logic                 gnt_vld_q, gnt_vld_d;
    logic [BIN_WIDTH-1:0] ptr_q, ptr_d;

    logic [N-1:0]         pick_req;
    logic [N-1:0]         win;
    logic [BIN_WIDTH-1:0] win_id;
    logic                 win_any;

    logic busy;
    logic done;
    logic owner_req;
    logic hold_hit;
    logic rel;

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = safe_clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;

    assign hold_hit    = busy && (hold_q == HOLD_W'(MAX_HOLD - 1));
    assign bus.timeout = timeout_q;
`else
    assign hold_hit = 1'b0;
`endif

    assign busy      = (state_q == BUSY);
    assign done      = bus.xfer & bus.last;
    assign owner_req = bus.req[gnt_id_q];
    assign rel       = busy & (done | ~owner_req | hold_hit);

    // The current owner is masked so a release hands over to someone else when possible.
    assign pick_req = bus.req & ~gnt_q;

    ldl_rr_pick #(.BIN_WIDTH(BIN_WIDTH)) u_pick (
        .req    (pick_req),
        .ptr    (ptr_q),
        .win    (win),
        .win_id (win_id),
        .any    (win_any)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        gnt_vld_d = gnt_vld_q;
        ptr_d     = ptr_q;
`ifdef ARB_TIMEOUT_EN
        hold_d    = busy ? hold_q + HOLD_W'(1) : hold_q;
        timeout_d = hold_hit & ~done & owner_req;
`endif
        if ((state_q == IDLE) || rel) begin
            if (win_any) begin
                state_d   = BUSY;
                gnt_d     = win;
                gnt_id_d  = win_id;
                gnt_vld_d = 1'b1;
                ptr_d     = win_id;
`ifdef ARB_TIMEOUT_EN
                hold_d    = '0;
`endif
            end else begin
                state_d   = IDLE;
                gnt_d     = '0;
                gnt_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            gnt_vld_q <= 1'b0;
            ptr_q     <= BIN_WIDTH'(N - 1);
`ifdef ARB_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            gnt_vld_q <= gnt_vld_d;
            ptr_q     <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.gnt_vld = gnt_vld_q;

endmodule

// File: doc/ldl_rr_arb_lock.md
Name: ldl_rr_arb_lock

Overview:
Round-robin arbiter with packet lock. It shares one downstream resource among N = 2**BIN_WIDTH requesters. A grant is held for a whole packet, until the last beat transfers or the owner withdraws its request. It emits the winner as both a one-hot vector and a binary index, so it sits directly in front of the team's hot-to-bin encoding and mux datapath.

Parameters:
BIN_WIDTH, 3, width of the binary grant index; requester count N = 1<<BIN_WIDTH
MAX_HOLD, 16, maximum grant length in cycles; used only when the timeout feature is compiled in; legal range is 2 or more

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  reset, asynchronous, active-low
req  input  N  per-requester request; the requester holds it until it is granted and done
xfer  input  1  a beat was accepted downstream this cycle
last  input  1  qualifies xfer: the beat is the final beat of the packet
gnt  output  N  one-hot grant, registered
gnt_id  output  BIN_WIDTH  binary index of the granted requester, registered
gnt_vld  output  1  a grant is active, registered
timeout  output  1  one-cycle pulse on a forced release; present only with ARB_TIMEOUT_EN

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - gnt=0, gnt_id=0, gnt_vld=0, timeout=0.
  - State=IDLE.
  - Round-robin pointer ptr=N-1, so requester 0 has top priority after reset.
- State IDLE:
  - If |req, pick the winner and move to BUSY.
  - gnt, gnt_id and gnt_vld are asserted on the next edge: latency 1 cycle from req to grant.
- Pick rule:
  - The winner is the lowest index strictly above ptr among asserted req bits.
  - If none is above ptr, wrap to the lowest asserted index.
  - On every grant, ptr is loaded with the winner's index.
- State BUSY: gnt, gnt_id and gnt_vld are held stable.
- Release condition, evaluated each cycle in BUSY: (xfer & last), OR req[gnt_id]==0 (abandon), OR forced timeout.
- On release:
  - Re-arbitrate in the same cycle with the owner's bit masked off.
  - If another request is pending, the new grant appears on the next edge with no idle bubble.
  - Otherwise go to IDLE; gnt and gnt_vld clear on the next edge.
  - gnt_id keeps its last value while gnt_vld=0.
- Input qualification:
  - xfer without last: no state change.
  - xfer or last while gnt_vld=0: ignored.
  - last without xfer: ignored.
- Simultaneous events: abandon and xfer&last in the same cycle give a single release; ptr is advanced once.
- Single requester: a requester may be re-granted back-to-back only if it is the sole requester at release. It is then masked, so it re-wins from IDLE one cycle later, leaving one bubble cycle.
- Reset mid-packet: all outputs clear immediately (asynchronously). The first grant after reset uses ptr=N-1.
- Invariant: gnt is always one-hot or zero; gnt == (gnt_vld << gnt_id).

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - Hold counter, width $clog2(MAX_HOLD+1), cleared on every grant and incremented each BUSY cycle.
  - When the counter reaches MAX_HOLD-1 without another release condition, release is forced and timeout pulses high for 1 cycle, coincident with the release edge.
  - Forced release follows the normal release and re-arbitration rules.
- Undefined: no counter and no timeout port; a grant is held indefinitely.

Decomposition:
- Shared package ldl_arb_pkg:
  - typedef enum of arbiter states {IDLE, BUSY}.
  - Function clog2-safe width helper.
  - Default MAX_HOLD constant.
- Sub-module ldl_rr_pick (combinational):
  - Inputs: req and ptr.
  - Outputs: the one-hot winner, its binary index, and an any flag.
  - Implemented as masked and unmasked lowest-index priority encoders.
  - Instantiated once in ldl_rr_arb_lock; the state, ptr and counter registers live in the top.

Test Plan:
1. Reset, req=8'h00 for 10 cycles -> gnt_vld=0, gnt=8'h00, gnt_id=0 throughout.
2. req=8'h01 at cycle 0; xfer=1 at cycles 2-3, last=1 at cycle 3 -> gnt=8'h01 and gnt_id=0 from cycle 1; gnt_vld=0 from cycle 4.
3. req=8'hFF held, each owner does one xfer&last the cycle after its grant -> gnt_id sequence 0,1,2,...,7,0 with gnt_vld continuously high (no bubble).
4. req=8'h24 with owner 2; drop req[2] mid-packet (xfer, no last) -> next edge gnt=8'h20, gnt_id=5.
5. BUSY with owner 3, pulse rst_n low for 1 cycle mid-packet -> outputs 0 immediately; after reset, req=8'h88 -> gnt_id=3 first, then 7.
6. ARB_TIMEOUT_EN, MAX_HOLD=16: req=8'h03, owner 0 never transfers -> release 16 cycles after grant, timeout=1 for 1 cycle, gnt_id=1 on the next edge.
